t_counter_ctrl: RTL and testbench
=================================

// Module: t_counter_ctrl
// PURPOSE
//   Programmable interval counter. Its count register is built from WIDTH toggle-flip-flop cells.
//   A control FSM computes each cell's T input every cycle to perform load, up-count,
//   down-count, hold and auto-reload.
//   Sits beside the T-FF datapath as its sequencer: periodic tick source / one-shot timer.
// PARAMETERS
//   WIDTH  4  count / period width in bits (>=2)
// PORTS
//   clk          in   1      system clock; every flop updates on the FALLING edge
//   reset        in   1      asynchronous, active-high; clears all state immediately
//   start        in   1      level, sampled per edge: (re)load and begin counting
//   stop         in   1      level, sampled per edge: abort to IDLE, count held
//   up_down      in   1      1 = count up 0..period, 0 = count down period..0; sampled at start
//   auto_reload  in   1      1 = reload at terminal and keep running; sampled at start
//   period       in   WIDTH  terminal (up) / initial (down) value; sampled at start
//   count        out  WIDTH  current cell contents
//   busy         out  1      state==RUN
//   tc_pulse     out  1      combinational: state==RUN && count==terminal
//   done         out  1      state==DONE
// BEHAVIOUR
//   Reset (async):
//     - cells, period_q, dir_q, reload_q = 0; state = IDLE.
//     - count=0, busy=0, tc_pulse=0, done=0.
//   Cell update rule: count_next = count ^ T, and T is the only path into the cells.
//     - load value V:  T = count ^ V
//     - up step:       T[0]=1, T[i] = &count[i-1:0]
//     - down step:     T[0]=1, T[i] = ~|count[i-1:0]
//     - hold:          T = 0
//   Terminal value = period_q when up, 0 when down. Reload value = 0 when up, period_q when down.
//   FSM, evaluated at each falling edge; stop has priority over start in every state:
//     IDLE: stop -> hold, stay. start -> capture period/up_down/auto_reload, load reload value, RUN.
//           else hold.
//     RUN:  stop -> hold, IDLE.
//           start -> recapture inputs + load, stay RUN (restart).
//           count==terminal -> if reload_q: load reload value, stay RUN; else: hold, DONE.
//           else -> one up/down step.
//     DONE: hold (done=1). stop -> IDLE. start -> recapture + load, RUN.
//   Timing:
//     - The first counted value appears at the edge after start.
//     - The terminal value is visible for exactly 1 cycle, with tc_pulse=1.
//     - Interval = period_q+1 cycles per tc_pulse with auto_reload.
//   Boundaries:
//     - period=0 + auto_reload: tc_pulse stays high every RUN cycle and count stays 0.
//     - period=0 without auto_reload: RUN lasts 1 cycle, then DONE.
//     - period=2^WIDTH-1 in up mode: counts the full range; wrap happens via reload, never by overflow.
//     - Input changes during RUN are ignored until the next start.
//     - Reset mid-operation aborts immediately; the next edge sees IDLE.
//   No intra-assignment delays in synthesizable code.
// STRUCTURE
//   Package t_counter_pkg:
//     - state enum IDLE=2'd0, RUN=2'd1, DONE=2'd2
//     - localparams for the T-vector select codes (LOAD/UP/DOWN/HOLD)
//   Sub-module t_cell:
//     - one toggle FF: negedge clk, async active-high reset, q <= q ^ t
//     - instantiated WIDTH times via generate
//   The top level holds the FSM, the captured-config registers and the T-vector mux.
// TESTING (WIDTH=4, all checks just after falling edges)
//   1. Reset asserted mid-RUN at count=5, asynchronously
//      -> count=0, busy=0, done=0 before the next edge.
//   2. Up one-shot: period=3, up_down=1, auto_reload=0, start 1 cycle
//      -> count 0,1,2,3; tc_pulse only at 3; then done=1 and count holds 3.
//   3. Down auto-reload: period=2, up_down=0, auto_reload=1
//      -> count 2,1,0,2,1,0...; tc_pulse every 3rd cycle; busy stays 1.
//   4. start and stop together in RUN at count=2 -> IDLE, count holds 2, busy=0.
//      A later start reloads to 0.
//   5. period changed 3->9 mid-run -> terminal stays 3.
//      Restart with start -> terminal becomes 9.
//   6. Edge periods, up mode:
//      - period=0 + auto_reload -> tc_pulse continuously 1, count=0.
//      - period=15 -> count 0..15, tc at 15, then reloads to 0.

Source files
------------

// File: rtl/t_counter_pkg.sv
// Shared types for the T-flip-flop interval counter: FSM state encoding and
// the select codes that choose which T vector drives the count cells.
package t_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] t_sel_t;

  localparam t_sel_t SEL_LOAD = 2'd0;
  localparam t_sel_t SEL_UP   = 2'd1;
  localparam t_sel_t SEL_DOWN = 2'd2;
  localparam t_sel_t SEL_HOLD = 2'd3;

endpackage

// File: rtl/t_counter_ctrl_if.sv
// Control/status bundle of the interval counter; the sequencer-side user is
// the master, the counter itself is the slave.
interface t_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             up_down;
  logic             auto_reload;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;
  logic             done;

  modport master (
    output start, stop, up_down, auto_reload, period,
    input  count, busy, tc_pulse, done
  );

  modport slave (
    input  start, stop, up_down, auto_reload, period,
    output count, busy, tc_pulse, done
  );
endinterface

// File: rtl/t_cell.sv
// Single toggle flip-flop: q flips on each falling edge where t is high.
module t_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= q ^ t;
  end

endmodule

// File: rtl/t_counter_ctrl.sv
// Programmable interval counter: an FSM sequences a row of toggle cells by
// computing each cell's T input for load, up/down step, hold and auto-reload.
module t_counter_ctrl
  import t_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  t_counter_ctrl_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period_q;
  logic             dir_q;
  logic             reload_q;
  logic             capture;
  t_sel_t           sel;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] t_up, t_dn, t_vec;
  logic [WIDTH-1:0] terminal, reload_val;
  logic             at_terminal;

  assign terminal    = dir_q ? period_q : '0;
  assign reload_val  = dir_q ? '0 : period_q;
  assign at_terminal = (count == terminal);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        period_q <= bus.period;
        dir_q    <= bus.up_down;
        reload_q <= bus.auto_reload;
      end
    end
  end

  // stop outranks start in every state; a start loads from the live inputs,
  // not the captured copies, since they are being captured on the same edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    sel      = SEL_HOLD;
    load_val = '0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          capture  = 1'b1;
          sel      = SEL_LOAD;
          load_val = bus.up_down ? '0 : bus.period;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          capture  = 1'b1;
          sel      = SEL_LOAD;
          load_val = bus.up_down ? '0 : bus.period;
        end else if (at_terminal) begin
          if (reload_q) begin
            sel      = SEL_LOAD;
            load_val = reload_val;
          end else begin
            state_d = DONE;
          end
        end else begin
          sel = dir_q ? SEL_UP : SEL_DOWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ripple-style toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] &  count[i-1];
      t_dn[i] = t_dn[i-1] & ~count[i-1];
    end
  end

  always_comb begin
    case (sel)
      SEL_LOAD: t_vec = count ^ load_val;
      SEL_UP:   t_vec = t_up;
      SEL_DOWN: t_vec = t_dn;
      default:  t_vec = '0;
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec[g]),
      .q     (count[g])
    );
  end

  assign bus.count    = count;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.tc_pulse = (state_q == RUN) && at_terminal;

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Self-checking bench for t_counter_ctrl: directed scenarios plus random
// traffic, compared every cycle against an arithmetic reference model.
module tb_t_counter_ctrl;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  t_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  t_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers and flags describing the timer's behaviour.
  int m_cnt;
  bit m_run;
  bit m_done;
  int m_per;
  bit m_up;
  bit m_rl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_done = 0; m_per = 0; m_up = 0; m_rl = 0;
  endtask

  task automatic model_step();
    int term;
    if (bus.stop) begin
      m_run  = 0;
      m_done = 0;
    end else if (bus.start) begin
      m_per  = int'(bus.period);
      m_up   = bus.up_down;
      m_rl   = bus.auto_reload;
      m_cnt  = m_up ? 0 : m_per;
      m_run  = 1;
      m_done = 0;
    end else if (m_run) begin
      term = m_up ? m_per : 0;
      if (m_cnt == term) begin
        if (m_rl) m_cnt = m_up ? 0 : m_per;
        else begin
          m_run  = 0;
          m_done = 1;
        end
      end else begin
        m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
      end
    end
  endtask

  function automatic bit model_tc();
    return m_run && (m_cnt == (m_up ? m_per : 0));
  endfunction

  task automatic cycle();
    @(negedge clk);
    if (!reset) model_step();
    #1;
    check("count", 32'(bus.count), 32'(m_cnt));
    check("busy", 32'(bus.busy), 32'(m_run));
    check("done", 32'(bus.done), 32'(m_done));
    check("tc_pulse", 32'(bus.tc_pulse), 32'(model_tc()));
  endtask

  task automatic pulse_start(input int p, input bit ud, input bit ar);
    bus.period      = WIDTH'(p);
    bus.up_down     = ud;
    bus.auto_reload = ar;
    bus.start       = 1'b1;
    cycle();
    bus.start       = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.start = 0; bus.stop = 0; bus.up_down = 0; bus.auto_reload = 0; bus.period = '0;
    model_reset();
    reset = 1'b1;
    #1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_tc", 32'(bus.tc_pulse), 0);
    @(posedge clk);
    reset = 1'b0;
    cycle();

    // 1. Async reset mid-run at count 5.
    pulse_start(9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    check("t1_pre", 32'(bus.count), 5);
    reset = 1'b1;
    model_reset();
    #1;
    check("t1_count", 32'(bus.count), 0);
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_done", 32'(bus.done), 0);
    #1;
    reset = 1'b0;
    cycle();
    check("t1_idle", 32'(bus.busy), 0);

    // 2. Up one-shot, period 3.
    pulse_start(3, 1'b1, 1'b0);
    check("t2_seq", 32'(bus.count), 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("t2_seq", 32'(bus.count), 32'(i));
      check("t2_tc", 32'(bus.tc_pulse), 32'(i == 3));
    end
    cycle();
    check("t2_done", 32'(bus.done), 1);
    check("t2_hold", 32'(bus.count), 3);
    cycle();
    check("t2_hold2", 32'(bus.count), 3);

    // 3. Down auto-reload, period 2.
    pulse_start(2, 1'b0, 1'b1);
    check("t3_first", 32'(bus.count), 2);
    for (int i = 0; i < 7; i++) begin
      int exp_c;
      cycle();
      exp_c = 2 - ((i + 1) % 3);
      check("t3_seq", 32'(bus.count), 32'(exp_c));
      check("t3_tc", 32'(bus.tc_pulse), 32'(exp_c == 0));
      check("t3_busy", 32'(bus.busy), 1);
    end

    // 4. start+stop together at count 2.
    pulse_start(9, 1'b1, 1'b0);
    cycle();
    cycle();
    check("t4_pre", 32'(bus.count), 2);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t4_count", 32'(bus.count), 2);
    check("t4_busy", 32'(bus.busy), 0);
    cycle();
    check("t4_idle_hold", 32'(bus.count), 2);
    pulse_start(9, 1'b1, 1'b0);
    check("t4_reload", 32'(bus.count), 0);

    // 5. Period change mid-run ignored until restart.
    pulse_start(3, 1'b1, 1'b0);
    bus.period = WIDTH'(9);
    for (int i = 0; i < 5; i++) cycle();
    check("t5_term3", 32'(bus.count), 3);
    check("t5_done", 32'(bus.done), 1);
    pulse_start(9, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle();
    check("t5_term9", 32'(bus.count), 9);
    check("t5_tc9", 32'(bus.tc_pulse), 1);
    cycle();
    check("t5_done9", 32'(bus.done), 1);

    // 6. Edge periods.
    pulse_start(0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t6_p0_tc", 32'(bus.tc_pulse), 1);
      check("t6_p0_cnt", 32'(bus.count), 0);
    end
    pulse_start(0, 1'b1, 1'b0);
    check("t6_p0os_busy", 32'(bus.busy), 1);
    cycle();
    check("t6_p0os_done", 32'(bus.done), 1);
    pulse_start(15, 1'b1, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      cycle();
      check("t6_p15", 32'(bus.count), 32'(i % 16));
      check("t6_p15_tc", 32'(bus.tc_pulse), 32'(i == 15));
    end

    // Random traffic against the model.
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.start       = ($urandom_range(0, 9) == 0);
      bus.stop        = ($urandom_range(0, 19) == 0);
      bus.up_down     = 1'($urandom);
      bus.auto_reload = 1'($urandom);
      bus.period      = WIDTH'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
